// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI address sequencer: one burst descriptor in, one beat record per cycle out.
// Optional 4 KB page / oversize check enabled by defining AXI_BURST_BOUNDARY_CHECK_EN.
module axi_burst_addr_gen #(
  parameter int AddrWidth = 32,
  parameter int IdWidth   = 4,
  parameter int DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [7:0]           req_len_i,
  input  logic [2:0]           req_size_i,
  input  logic [1:0]           req_burst_i,
  input  logic [IdWidth-1:0]   req_id_i,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [AddrWidth-1:0] beat_addr_o,
  output logic [7:0]           beat_idx_o,
  output logic                 beat_last_o,
  output logic [IdWidth-1:0]   beat_id_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int              MaxSize  = $clog2(DataWidth / 8);
  localparam logic [2:0]      MaxSizeL = 3'(MaxSize);

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } burst_e;

  typedef enum logic {
    StIdle,
    StBurst
  } state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0] addr_q;
  logic [AddrWidth-1:0] base_q;
  logic [AddrWidth-1:0] off_q;
  logic [AddrWidth-1:0] mask_q;
  logic [AddrWidth-1:0] bytes_q;
  logic [7:0]           idx_q;
  logic [7:0]           len_q;
  logic [IdWidth-1:0]   id_q;
  logic                 fixed_q;

  // Descriptor decode (legalised size and burst type)
  logic [2:0]           size_eff;
  logic [AddrWidth-1:0] bytes_in;
  logic [AddrWidth-1:0] aligned_in;
  logic [AddrWidth-1:0] mask_in;
  logic                 wrap_legal;
  logic                 fixed_in;
  logic [2:0]           len_log2;
  logic [3:0]           wrap_sh;

  logic                 load;
  logic                 step;
  logic [AddrWidth-1:0] off_next;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    size_eff   = (req_size_i > MaxSizeL) ? MaxSizeL : req_size_i;
    bytes_in   = AddrWidth'(1) << size_eff;
    aligned_in = req_addr_i & ~(bytes_in - AddrWidth'(1));
    fixed_in   = (burst_e'(req_burst_i) == BurstFixed);
    wrap_legal = 1'b0;
    len_log2   = 3'd0;
    if (burst_e'(req_burst_i) == BurstWrap) begin
      case (req_len_i)
        8'd1:    begin wrap_legal = 1'b1; len_log2 = 3'd1; end
        8'd3:    begin wrap_legal = 1'b1; len_log2 = 3'd2; end
        8'd7:    begin wrap_legal = 1'b1; len_log2 = 3'd3; end
        8'd15:   begin wrap_legal = 1'b1; len_log2 = 3'd4; end
        default: begin wrap_legal = 1'b0; len_log2 = 3'd0; end
      endcase
    end
    wrap_sh = {1'b0, size_eff} + {1'b0, len_log2};
    // INCR (and every demoted WRAP) is a wrap over the whole address space.
    mask_in = wrap_legal ? ~({AddrWidth{1'b1}} << wrap_sh) : {AddrWidth{1'b1}};
  end

  // Output process
  always_comb begin
    beat_valid_o = (state_q == StBurst);
    busy_o       = (state_q == StBurst);
    beat_last_o  = (state_q == StBurst) && (idx_q == len_q);
    req_ready_o  = (state_q == StIdle) || (beat_last_o && beat_ready_i);
  end

  assign load = req_valid_i && req_ready_o;
  assign step = beat_valid_o && beat_ready_i && !beat_last_o;

  // Next-state process
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) state_d = StBurst;
      end
      StBurst: begin
        if (beat_ready_i && beat_last_o) state_d = req_valid_i ? StBurst : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  assign off_next = (off_q + bytes_q) & mask_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      base_q  <= '0;
      off_q   <= '0;
      mask_q  <= '0;
      bytes_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      id_q    <= '0;
      fixed_q <= 1'b0;
    end else if (load) begin
      addr_q  <= req_addr_i;
      base_q  <= aligned_in & ~mask_in;
      off_q   <= aligned_in & mask_in;
      mask_q  <= mask_in;
      bytes_q <= bytes_in;
      idx_q   <= '0;
      len_q   <= req_len_i;
      id_q    <= req_id_i;
      fixed_q <= fixed_in;
    end else if (step) begin
      idx_q <= idx_q + 8'd1;
      if (!fixed_q) begin
        off_q  <= off_next;
        addr_q <= base_q | off_next;
      end
    end
  end

  assign beat_addr_o = addr_q;
  assign beat_idx_o  = idx_q;
  assign beat_id_o   = id_q;

`ifdef AXI_BURST_BOUNDARY_CHECK_EN
  // Extra headroom so a burst running past the top of the address space reads as a page cross.
  localparam int ExtWidth = AddrWidth + 16;

  logic [ExtWidth-1:0] last_byte;
  logic                page_cross;
  logic                size_err;
  logic                err_q;

  always_comb begin
    last_byte  = ExtWidth'(aligned_in)
               + ((ExtWidth'(req_len_i) + ExtWidth'(1)) << size_eff)
               - ExtWidth'(1);
    page_cross = !fixed_in && !wrap_legal
               && ((last_byte >> 12) != (ExtWidth'(req_addr_i) >> 12));
    size_err   = (req_size_i > MaxSizeL);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= load && (page_cross || size_err);
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Self-checking bench for axi_burst_addr_gen: directed plan items plus randomized bursts
// checked cycle by cycle against an arithmetic reference model.
module tb_axi_burst_addr_gen;

  localparam int AW   = 32;
  localparam int IW   = 4;
  localparam int DW   = 64;
  localparam int MAXS = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [7:0]    req_len_i;
  logic [2:0]    req_size_i;
  logic [1:0]    req_burst_i;
  logic [IW-1:0] req_id_i;
  logic          beat_valid_o;
  logic          beat_ready_i;
  logic [AW-1:0] beat_addr_o;
  logic [7:0]    beat_idx_o;
  logic          beat_last_o;
  logic [IW-1:0] beat_id_o;
  logic          busy_o;
  logic          err_o;

  int total = 0;
  int bad   = 0;

  axi_burst_addr_gen #(.AddrWidth(AW), .IdWidth(IW), .DataWidth(DW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_len_i    (req_len_i),
    .req_size_i   (req_size_i),
    .req_burst_i  (req_burst_i),
    .req_id_i     (req_id_i),
    .beat_valid_o (beat_valid_o),
    .beat_ready_i (beat_ready_i),
    .beat_addr_o  (beat_addr_o),
    .beat_idx_o   (beat_idx_o),
    .beat_last_o  (beat_last_o),
    .beat_id_o    (beat_id_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: addresses straight from the burst arithmetic rules.
  function automatic int eff_size(input logic [2:0] s);
    return (int'(s) > MAXS) ? MAXS : int'(s);
  endfunction

  function automatic int eff_burst(input logic [1:0] b, input int len);
    if (b == 2'b11) return 1;
    if (b == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1;
    return int'(b);
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] addr, input int len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int n);
    longint unsigned a, bytes, aligned, span, base;
    int b;
    a       = longint'(addr);
    bytes   = longint'(1) << eff_size(size);
    aligned = a - (a % bytes);
    b       = eff_burst(burst, len);
    if (n == 0 || b == 0) return addr;
    if (b == 1) return 32'(aligned + longint'(n) * bytes);
    span = bytes * longint'(len + 1);
    base = a - (a % span);
    return 32'(base + ((aligned - base + longint'(n) * bytes) % span));
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input int len,
                                   input logic [2:0] size, input logic [1:0] burst);
`ifdef AXI_BURST_BOUNDARY_CHECK_EN
    longint unsigned a, bytes, aligned, last;
    a       = longint'(addr);
    bytes   = longint'(1) << eff_size(size);
    aligned = a - (a % bytes);
    last    = aligned + longint'(len + 1) * bytes - 1;
    if (int'(size) > MAXS) return 1'b1;
    return (eff_burst(burst, len) == 1) && ((last >> 12) != (a >> 12));
`else
    return 1'b0;
`endif
  endfunction

  // Issue one descriptor from idle and follow every cycle of its beats against the model.
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int pct,
                           input int stall_idx, input int stall_cycles, input string tag);
    int n, cyc, stalled;
    bit first;
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    req_addr_i   = addr;
    req_len_i    = len;
    req_size_i   = size;
    req_burst_i  = burst;
    req_id_i     = id;
    beat_ready_i = 1'b0;
    #1;
    check({tag, "_accept_ready"}, 64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    n = 0; cyc = 0; stalled = 0; first = 1'b1;
    while (n <= int'(len) && cyc < 2000) begin
      if (n == stall_idx && stalled < stall_cycles) begin
        beat_ready_i = 1'b0;
        stalled++;
      end else begin
        beat_ready_i = ($urandom_range(99) < pct);
      end
      #1;
      check({tag, "_valid"}, 64'(beat_valid_o), 64'd1);
      check({tag, "_busy"},  64'(busy_o), 64'd1);
      check({tag, "_addr"},  64'(beat_addr_o), 64'(model_addr(addr, int'(len), size, burst, n)));
      check({tag, "_idx"},   64'(beat_idx_o), 64'(n));
      check({tag, "_last"},  64'(beat_last_o), 64'(n == int'(len)));
      check({tag, "_id"},    64'(beat_id_o), 64'(id));
      check({tag, "_err"},   64'(err_o),
            64'(first ? model_err(addr, int'(len), size, burst) : 1'b0));
      first = 1'b0;
      if (beat_ready_i) n++;
      @(negedge clk_i);
      cyc++;
    end
    check({tag, "_completed"}, 64'(n > int'(len)), 64'd1);
    beat_ready_i = 1'b0;
    #1;
    check({tag, "_end_valid"}, 64'(beat_valid_o), 64'd0);
    check({tag, "_end_busy"},  64'(busy_o), 64'd0);
    check({tag, "_end_ready"}, 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;

    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_len_i    = '0;
    req_size_i   = '0;
    req_burst_i  = '0;
    req_id_i     = '0;
    beat_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_valid", 64'(beat_valid_o), 64'd0);
    check("rst_busy",  64'(busy_o), 64'd0);
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_last",  64'(beat_last_o), 64'd0);
    check("rst_addr",  64'(beat_addr_o), 64'd0);
    check("rst_idx",   64'(beat_idx_o), 64'd0);
    check("rst_id",    64'(beat_id_o), 64'd0);
    check("rst_err",   64'(err_o), 64'd0);
    rst_ni = 1'b1;

    // Directed plan items
    run_burst(32'h1002, 8'd3, 3'd2, 2'b01, 4'h3, 100, -1, 0, "incr_unaligned");
    run_burst(32'h1008, 8'd3, 3'd2, 2'b10, 4'h5, 100, -1, 0, "wrap4");
    run_burst(32'h1008, 8'd2, 3'd2, 2'b10, 4'h6, 100, -1, 0, "wrap3_as_incr");
    run_burst(32'h0020, 8'd2, 3'd2, 2'b00, 4'h7, 100,  1, 3, "fixed_stall");
    run_burst(32'h0100, 8'd0, 3'd1, 2'b01, 4'h8, 100, -1, 0, "len0");
    run_burst(32'h2003, 8'd3, 3'd6, 2'b01, 4'h9, 100, -1, 0, "size_clamp");
    run_burst(32'h3010, 8'd2, 3'd3, 2'b11, 4'ha, 100, -1, 0, "rsvd_as_incr");
    run_burst(32'h0FF8, 8'd3, 3'd2, 2'b01, 4'hb, 100, -1, 0, "page_cross");
    run_burst(32'h0FF0, 8'd3, 3'd2, 2'b01, 4'hc, 100, -1, 0, "page_ok");
    run_burst(32'hFFFF_FFF8, 8'd3, 3'd3, 2'b01, 4'hd, 100, -1, 0, "addr_wrap");

    // Back-to-back: second burst's beat 0 directly follows first burst's last beat.
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    req_addr_i   = 32'h2000;
    req_len_i    = 8'd3;
    req_size_i   = 3'd3;
    req_burst_i  = 2'b01;
    req_id_i     = 4'h1;
    beat_ready_i = 1'b1;
    @(negedge clk_i);
    req_addr_i  = 32'h3004;
    req_len_i   = 8'd1;
    req_size_i  = 3'd2;
    req_id_i    = 4'h2;
    for (int i = 0; i <= 3; i++) begin
      #1;
      check("b2b_a_valid", 64'(beat_valid_o), 64'd1);
      check("b2b_a_addr",  64'(beat_addr_o), 64'(model_addr(32'h2000, 3, 3'd3, 2'b01, i)));
      check("b2b_a_idx",   64'(beat_idx_o), 64'(i));
      check("b2b_a_last",  64'(beat_last_o), 64'(i == 3));
      check("b2b_a_ready", 64'(req_ready_o), 64'(i == 3));
      @(negedge clk_i);
    end
    req_valid_i = 1'b0;
    for (int j = 0; j <= 1; j++) begin
      #1;
      check("b2b_b_valid", 64'(beat_valid_o), 64'd1);
      check("b2b_b_addr",  64'(beat_addr_o), 64'(model_addr(32'h3004, 1, 3'd2, 2'b01, j)));
      check("b2b_b_idx",   64'(beat_idx_o), 64'(j));
      check("b2b_b_last",  64'(beat_last_o), 64'(j == 1));
      check("b2b_b_id",    64'(beat_id_o), 64'h2);
      @(negedge clk_i);
    end
    #1;
    check("b2b_end_valid", 64'(beat_valid_o), 64'd0);
    beat_ready_i = 1'b0;

    // Reset during idx 2 of a len=7 burst.
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    req_addr_i   = 32'h4000;
    req_len_i    = 8'd7;
    req_size_i   = 3'd2;
    req_burst_i  = 2'b01;
    req_id_i     = 4'h4;
    beat_ready_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("mid_rst_idx_before", 64'(beat_idx_o), 64'd2);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("mid_rst_valid", 64'(beat_valid_o), 64'd0);
    check("mid_rst_busy",  64'(busy_o), 64'd0);
    check("mid_rst_ready", 64'(req_ready_o), 64'd1);
    check("mid_rst_last",  64'(beat_last_o), 64'd0);
    @(negedge clk_i);
    #1;
    check("mid_rst_quiet", 64'(beat_valid_o), 64'd0);
    beat_ready_i = 1'b0;
    run_burst(32'h5004, 8'd3, 3'd2, 2'b10, 4'he, 100, -1, 0, "after_rst");

    // Randomized descriptors with random back-pressure.
    for (int k = 0; k < 30; k++) begin
      r_addr  = $urandom;
      r_size  = 3'($urandom_range(7));
      r_burst = 2'($urandom_range(3));
      if (r_burst == 2'b10 && $urandom_range(1) == 1)
        r_len = 8'((2 << $urandom_range(3)) - 1);
      else if ($urandom_range(7) == 0)
        r_len = 8'($urandom_range(255));
      else
        r_len = 8'($urandom_range(15));
      run_burst(r_addr, r_len, r_size, r_burst, 4'($urandom), int'($urandom_range(100, 50)),
                int'($urandom_range(3)), int'($urandom_range(2)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_addr_gen.md
Name: axi_burst_addr_gen

Overview:
- Per-beat AXI address sequencer for the crossbar's slave-side ports.
- Accepts one AW/AR burst descriptor (addr, len, size, burst, id) per valid/ready handshake.
- Emits one beat record per cycle on a second valid/ready interface, with FIXED, INCR and WRAP address arithmetic, beat index and last flag.
- Generalised over address width, ID width and data-bus width; zero-bubble back-to-back bursts.

Parameters:
- AddrWidth, 32, address width in bits.
- IdWidth, 4, transaction ID width.
- DataWidth, 64, data bus width in bits (power of two, 8..1024). Sets the maximum legal beat size: log2(DataWidth/8).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  1  descriptor valid
- req_ready_o  out  1  descriptor accepted
- req_addr_i  in  AddrWidth  start address
- req_len_i  in  8  beats minus one (LenWidth)
- req_size_i  in  3  log2 bytes per beat (SizeWidth)
- req_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved (BurstWidth)
- req_id_i  in  IdWidth  transaction ID
- beat_valid_o  out  1  beat record valid
- beat_ready_i  in  1  beat consumed
- beat_addr_o  out  AddrWidth  beat address
- beat_idx_o  out  8  beat number, 0..len
- beat_last_o  out  1  final beat of burst
- beat_id_o  out  IdWidth  ID of current burst
- busy_o  out  1  burst in progress
- err_o  out  1  burst error pulse (only with optional feature; tied 0 otherwise)

Behaviour:
- Reset: clock and reset ports are clk_i and rst_ni; rst_ni is synchronous, active-low. All outputs are 0 in reset except req_ready_o; state goes to IDLE.
- FSM IDLE: req_ready_o=1, beat_valid_o=0. On req handshake:
  - latch the descriptor;
  - go to BURST;
  - beat 0 is presented the next cycle (latency 1).
- FSM BURST: beat_valid_o=1, busy_o=1, req_ready_o = beat_last_o & beat_ready_i (combinational; allows a back-to-back accept).
- Beat stepping:
  - Each beat handshake increments beat_idx_o.
  - The last-beat handshake with no new request returns to IDLE.
  - The last-beat handshake together with a new request loads the new descriptor and stays in BURST, with no bubble.
- Stall: while beat_valid_o & !beat_ready_i, all beat_* outputs hold stable.
- Addressing: bytes = 1<<size; aligned = addr with low size bits cleared.
  - Beat 0 is always req_addr_i unmodified (unaligned start permitted).
  - FIXED: every beat = req_addr_i.
  - INCR: beat n = aligned + n*bytes for n≥1, modulo 2^AddrWidth.
  - WRAP: span = bytes*(len+1); base = addr with low log2(span) bits cleared; beat n = base + ((aligned - base + n*bytes) mod span).
- Legalisation:
  - burst=11 is treated as INCR.
  - WRAP with len+1 not in {2,4,8,16} is treated as INCR.
  - size > log2(DataWidth/8) is clamped to the maximum.
- len=0: a single beat, with beat_last_o=1 on beat 0.
- Reset mid-burst: the burst is abandoned and no further beats are emitted.

Optional Feature:
- Macro: AXI_BURST_BOUNDARY_CHECK_EN.
- Defined: at descriptor accept, the block checks for two errors:
  - an INCR/WRAP burst whose last byte lies in a different 4 KB page than its first byte;
  - original req_size_i > log2(DataWidth/8).
- On either error, err_o pulses 1 cycle, coincident with beat 0 being presented. Beats are still generated as specified above.
- Not defined: the checker is absent and err_o is constant 0.

Test Plan:
- INCR addr=0x1002 len=3 size=2 -> beats 0x1002, 0x1004, 0x1008, 0x100C; idx 0..3; last on idx 3; first beat 1 cycle after accept.
- WRAP addr=0x1008 len=3 size=2 -> 0x1008, 0x100C, 0x1000, 0x1004; WRAP len=2 -> behaves as INCR: 0x1008, 0x100C, 0x1010.
- FIXED addr=0x20 len=2, beat_ready_i low for 3 cycles on idx 1 -> 0x20 ×3; outputs stable during the stall; no beat lost or duplicated.
- Two INCR bursts with req_valid_i held high and beat_ready_i=1 -> second burst's beat 0 appears the cycle after the first burst's last beat; no idle cycle.
- With AXI_BURST_BOUNDARY_CHECK_EN: INCR addr=0xFF8 len=3 size=2 -> err_o=1 for one cycle with beat 0. INCR addr=0xFF0 len=3 size=2 -> err_o stays 0.
- rst_ni low for 1 cycle during idx 2 of a len=7 burst -> next cycle beat_valid_o=0, busy_o=0, req_ready_o=1; a subsequent burst runs correctly.
